// File: rtl/commit_trace_pkg.sv
// Record layout, event kinds and packing helpers for the commit trace collector.
// Defining TRACE_TIMESTAMP_EN adds a 64-bit tstamp field to trace_rec_t.
package commit_trace_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned VLEN       = 64;
  localparam int unsigned DROP_CNT_W = 16;
  localparam int unsigned TSTAMP_W   = 64;

  typedef enum logic [1:0] {
    INSTR = 2'd0,
    EXC   = 2'd1,
    LOST  = 2'd2
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e       kind;
    logic [VLEN-1:0]   pc;
    logic [31:0]       instr;
    logic [4:0]        rd;
    logic              we;
    logic              fpr;
    logic [XLEN-1:0]   wdata;
    logic [1:0]        priv;
    logic              dbg;
    logic [XLEN-1:0]   cause;
    logic [XLEN-1:0]   tval;
`ifdef TRACE_TIMESTAMP_EN
    logic [TSTAMP_W-1:0] tstamp;
`endif
  } trace_rec_t;

  function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                    input logic [DROP_CNT_W-1:0] b);
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DROP_CNT_W] ? '1 : sum[DROP_CNT_W-1:0];
  endfunction

  // Write data is only meaningful when the register write is valid.
  function automatic trace_rec_t pack_instr(input logic [VLEN-1:0] pc,
                                            input logic [31:0]     instr,
                                            input logic [4:0]      rd,
                                            input logic            we,
                                            input logic            fpr,
                                            input logic [XLEN-1:0] wdata,
                                            input logic [1:0]      priv,
                                            input logic            dbg);
    trace_rec_t r;
    r       = '0;
    r.kind  = INSTR;
    r.pc    = pc;
    r.instr = instr;
    r.rd    = rd;
    r.we    = we;
    r.fpr   = fpr;
    r.wdata = we ? wdata : '0;
    r.priv  = priv;
    r.dbg   = dbg;
    return r;
  endfunction

  function automatic trace_rec_t pack_exc(input logic [VLEN-1:0] pc,
                                          input logic [XLEN-1:0] cause,
                                          input logic [XLEN-1:0] tval,
                                          input logic [1:0]      priv,
                                          input logic            dbg);
    trace_rec_t r;
    r       = '0;
    r.kind  = EXC;
    r.pc    = pc;
    r.cause = cause;
    r.tval  = tval;
    r.priv  = priv;
    r.dbg   = dbg;
    return r;
  endfunction

  function automatic trace_rec_t pack_lost(input logic [XLEN-1:0] cause);
    trace_rec_t r;
    r       = '0;
    r.kind  = LOST;
    r.cause = cause;
    return r;
  endfunction

endpackage

// File: rtl/trace_rec_fifo.sv
// In-order record FIFO: up to NR_PUSH writes per cycle, one pop, first-word fall-through head.
// Storage is registered; head reads back as zero while empty.
module trace_rec_fifo
  import commit_trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned NR_PUSH = 3,
  parameter int unsigned CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic [CNT_W-1:0] push_cnt_i,
  input  trace_rec_t       push_rec_i [NR_PUSH],
  input  logic             pop_i,
  output logic [CNT_W-1:0] free_o,
  output logic             empty_o,
  output trace_rec_t       head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  trace_rec_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             pop_eff;

  assign empty_o = (count_reg == '0);
  assign pop_eff = pop_i && !empty_o;
  assign free_o  = CNT_W'(DEPTH) - count_reg;
  assign head_o  = empty_o ? '0 : mem[rd_ptr_reg];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (clear_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // Pointer width is log2(DEPTH), so the truncated add wraps modulo DEPTH.
      wr_ptr_next = wr_ptr_reg + push_cnt_i[PTR_W-1:0];
      rd_ptr_next = rd_ptr_reg + PTR_W'(pop_eff);
      count_next  = count_reg + push_cnt_i - CNT_W'(pop_eff);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(NR_PUSH); i++) begin
      if (!clear_i && (CNT_W'(i) < push_cnt_i)) begin
        mem[wr_ptr_reg + PTR_W'(i)] <= push_rec_i[i];
      end
    end
  end

endmodule

// File: rtl/commit_trace_collector.sv
// Captures retiring instructions and exceptions into trace records, buffered for a valid/ready sink.
// Overflow never stalls commit: drops are counted and a LOST marker is queued once space returns.
// Optional macro TRACE_TIMESTAMP_EN stamps every record with a free-running cycle counter.
module commit_trace_collector
  import commit_trace_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned DEPTH           = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   clear_i,
  input  logic [NR_COMMIT_PORTS-1:0]             commit_ack_i,
  input  logic [NR_COMMIT_PORTS-1:0][VLEN-1:0]   commit_pc_i,
  input  logic [NR_COMMIT_PORTS-1:0][31:0]       commit_instr_i,
  input  logic [NR_COMMIT_PORTS-1:0]             commit_we_i,
  input  logic [NR_COMMIT_PORTS-1:0]             commit_fpr_i,
  input  logic [NR_COMMIT_PORTS-1:0][4:0]        commit_waddr_i,
  input  logic [NR_COMMIT_PORTS-1:0][XLEN-1:0]   commit_wdata_i,
  input  logic [1:0]                             priv_lvl_i,
  input  logic                                   debug_mode_i,
  input  logic                                   ex_valid_i,
  input  logic [XLEN-1:0]                        ex_cause_i,
  input  logic [XLEN-1:0]                        ex_tval_i,
  output logic                                   trace_valid_o,
  input  logic                                   trace_ready_i,
  output trace_rec_t                             trace_rec_o,
  output logic                                   overflow_o,
  output logic [DROP_CNT_W-1:0]                  drop_cnt_o
);

  localparam int unsigned NR_SLOTS = NR_COMMIT_PORTS + 1;
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_LOST = 1'b1
  } state_e;

  state_e                state_reg, state_next;
  logic [DROP_CNT_W-1:0] drop_cnt_reg, drop_cnt_next, drop_sum;
  logic                  overflow_reg, overflow_next;

  trace_rec_t       instr_rec [NR_COMMIT_PORTS];
  trace_rec_t       exc_rec;
  trace_rec_t       slot_rec  [NR_SLOTS];
  trace_rec_t       push_rec  [NR_SLOTS];
  logic [CNT_W-1:0] slot_pos  [NR_COMMIT_PORTS];
  logic [CNT_W-1:0] ex_pos;
  logic [CNT_W-1:0] ev_cnt;
  logic [CNT_W-1:0] push_cnt;
  logic [CNT_W-1:0] free_cnt;
  logic             fifo_empty;
  logic             pop;

`ifdef TRACE_TIMESTAMP_EN
  logic [TSTAMP_W-1:0] tstamp_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) tstamp_reg <= '0;
    else         tstamp_reg <= tstamp_reg + 1'b1;
  end
`endif

  generate
    for (genvar gi = 0; gi < int'(NR_COMMIT_PORTS); gi++) begin : g_pack
      assign instr_rec[gi] = pack_instr(commit_pc_i[gi], commit_instr_i[gi], commit_waddr_i[gi],
                                        commit_we_i[gi], commit_fpr_i[gi], commit_wdata_i[gi],
                                        priv_lvl_i, debug_mode_i);
    end
  endgenerate

  assign exc_rec = pack_exc(commit_pc_i[0], ex_cause_i, ex_tval_i, priv_lvl_i, debug_mode_i);

  // Each event's slot is the number of events ahead of it: port 0, port 1, then exception.
  always_comb begin
    ev_cnt = '0;
    for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
      slot_pos[p] = ev_cnt;
      ev_cnt      = ev_cnt + CNT_W'(commit_ack_i[p]);
    end
    ex_pos = ev_cnt;
    ev_cnt = ev_cnt + CNT_W'(ex_valid_i);
  end

  always_comb begin
    for (int s = 0; s < int'(NR_SLOTS); s++) begin
      slot_rec[s] = '0;
      for (int p = 0; p < int'(NR_COMMIT_PORTS); p++) begin
        if (commit_ack_i[p] && (slot_pos[p] == CNT_W'(s))) slot_rec[s] = instr_rec[p];
      end
      if (ex_valid_i && (ex_pos == CNT_W'(s))) slot_rec[s] = exc_rec;
    end
  end

  always_comb begin
    state_next    = state_reg;
    drop_cnt_next = drop_cnt_reg;
    overflow_next = overflow_reg;
    push_cnt      = '0;
    drop_sum      = sat_add(drop_cnt_reg, DROP_CNT_W'(ev_cnt));
    for (int s = 0; s < int'(NR_SLOTS); s++) push_rec[s] = slot_rec[s];

    if (clear_i) begin
      state_next    = ST_RUN;
      drop_cnt_next = '0;
      overflow_next = 1'b0;
    end else begin
      // free_cnt ignores this cycle's pop, so a full FIFO never admits a same-cycle push.
      unique case (state_reg)
        ST_RUN: begin
          if (free_cnt >= ev_cnt) begin
            push_cnt = ev_cnt;
          end else begin
            drop_cnt_next = drop_sum;
            overflow_next = 1'b1;
            state_next    = ST_LOST;
          end
        end
        ST_LOST: begin
          drop_cnt_next = drop_sum;
          if (free_cnt != '0) begin
            push_cnt    = CNT_W'(1);
            push_rec[0] = pack_lost(XLEN'(drop_sum));
            state_next  = ST_RUN;
          end
        end
        default: state_next = ST_RUN;
      endcase
    end

`ifdef TRACE_TIMESTAMP_EN
    for (int s = 0; s < int'(NR_SLOTS); s++) push_rec[s].tstamp = tstamp_reg;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= ST_RUN;
      drop_cnt_reg <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      drop_cnt_reg <= drop_cnt_next;
      overflow_reg <= overflow_next;
    end
  end

  assign pop           = trace_valid_o && trace_ready_i;
  assign trace_valid_o = !fifo_empty;
  assign overflow_o    = overflow_reg;
  assign drop_cnt_o    = drop_cnt_reg;

  trace_rec_fifo #(
    .DEPTH   (DEPTH),
    .NR_PUSH (NR_SLOTS),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (clear_i),
    .push_cnt_i (push_cnt),
    .push_rec_i (push_rec),
    .pop_i      (pop),
    .free_o     (free_cnt),
    .empty_o    (fifo_empty),
    .head_o     (trace_rec_o)
  );

endmodule

// File: tb/tb_commit_trace_collector.sv
// Scoreboard bench for commit_trace_collector: expected records are queued at drive time, compared on pop.
module tb_commit_trace_collector;
  import commit_trace_pkg::*;

  localparam int NR    = 2;
  localparam int DEPTH = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    clear;
  logic [NR-1:0]           ack;
  logic [NR-1:0][VLEN-1:0] pc;
  logic [NR-1:0][31:0]     instr;
  logic [NR-1:0]           we;
  logic [NR-1:0]           fpr;
  logic [NR-1:0][4:0]      waddr;
  logic [NR-1:0][XLEN-1:0] wdata;
  logic [1:0]              priv;
  logic                    dbg;
  logic                    ex_valid;
  logic [XLEN-1:0]         ex_cause;
  logic [XLEN-1:0]         ex_tval;
  logic                    valid;
  logic                    ready;
  trace_rec_t              rec;
  logic                    ovf;
  logic [DROP_CNT_W-1:0]   drop_cnt;

  always #5 clk = ~clk;

  commit_trace_collector #(.NR_COMMIT_PORTS(NR), .DEPTH(DEPTH)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .clear_i        (clear),
    .commit_ack_i   (ack),
    .commit_pc_i    (pc),
    .commit_instr_i (instr),
    .commit_we_i    (we),
    .commit_fpr_i   (fpr),
    .commit_waddr_i (waddr),
    .commit_wdata_i (wdata),
    .priv_lvl_i     (priv),
    .debug_mode_i   (dbg),
    .ex_valid_i     (ex_valid),
    .ex_cause_i     (ex_cause),
    .ex_tval_i      (ex_tval),
    .trace_valid_o  (valid),
    .trace_ready_i  (ready),
    .trace_rec_o    (rec),
    .overflow_o     (ovf),
    .drop_cnt_o     (drop_cnt)
  );

  trace_rec_t            exp_q[$];
  int                    n_checks = 0;
  int                    n_errors = 0;
  logic                  m_lost;
  logic [DROP_CNT_W-1:0] m_drop;
  logic                  m_ovf;

`ifdef TRACE_TIMESTAMP_EN
  logic [63:0] tb_cycle;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cycle <= '0;
    else        tb_cycle <= tb_cycle + 64'd1;
  end
`endif

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic trace_rec_t exp_instr(input int p);
    trace_rec_t r;
    r       = '0;
    r.kind  = INSTR;
    r.pc    = pc[p];
    r.instr = instr[p];
    r.rd    = waddr[p];
    r.we    = we[p];
    r.fpr   = fpr[p];
    r.wdata = we[p] ? wdata[p] : '0;
    r.priv  = priv;
    r.dbg   = dbg;
`ifdef TRACE_TIMESTAMP_EN
    r.tstamp = tb_cycle;
`endif
    return r;
  endfunction

  function automatic trace_rec_t exp_exc();
    trace_rec_t r;
    r       = '0;
    r.kind  = EXC;
    r.pc    = pc[0];
    r.cause = ex_cause;
    r.tval  = ex_tval;
    r.priv  = priv;
    r.dbg   = dbg;
`ifdef TRACE_TIMESTAMP_EN
    r.tstamp = tb_cycle;
`endif
    return r;
  endfunction

  function automatic trace_rec_t exp_lost(input logic [DROP_CNT_W-1:0] cnt);
    trace_rec_t r;
    r       = '0;
    r.kind  = LOST;
    r.cause = XLEN'(cnt);
`ifdef TRACE_TIMESTAMP_EN
    r.tstamp = tb_cycle;
`endif
    return r;
  endfunction

  function automatic logic [DROP_CNT_W-1:0] sat16(input logic [DROP_CNT_W-1:0] a, input int n);
    int s;
    s = int'(a) + n;
    return (s > 65535) ? 16'hFFFF : DROP_CNT_W'(s);
  endfunction

  task automatic idle_inputs();
    clear = 1'b0; ack = '0; pc = '0; instr = '0; we = '0; fpr = '0; waddr = '0; wdata = '0;
    priv = 2'd3; dbg = 1'b0; ex_valid = 1'b0; ex_cause = '0; ex_tval = '0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_lost = 1'b0;
    m_drop = '0;
    m_ovf  = 1'b0;
  endtask

  // One clock: score the head/pop, predict pushes from pre-pop occupancy, then check counters.
  task automatic run_cycle();
    int         occ;
    int         n;
    trace_rec_t e;
    occ = exp_q.size();
    n   = $countones(ack) + int'(ex_valid);
    check("valid", 512'(valid), 512'(occ != 0));
    if (!clear && ready && occ != 0) begin
      e = exp_q.pop_front();
      $display("pop kind=%0d pc=%0h cause=%0h wdata=%0h", rec.kind, rec.pc, rec.cause, rec.wdata);
      check("rec", 512'(rec), 512'(e));
    end
    if (clear) begin
      model_reset();
    end else if (!m_lost) begin
      if (DEPTH - occ >= n) begin
        for (int p = 0; p < NR; p++) if (ack[p]) exp_q.push_back(exp_instr(p));
        if (ex_valid) exp_q.push_back(exp_exc());
      end else begin
        m_drop = sat16(m_drop, n);
        m_ovf  = 1'b1;
        m_lost = 1'b1;
      end
    end else begin
      m_drop = sat16(m_drop, n);
      if (DEPTH - occ >= 1) begin
        exp_q.push_back(exp_lost(m_drop));
        m_lost = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("drop_cnt", 512'(drop_cnt), 512'(m_drop));
    check("overflow", 512'(ovf), 512'(m_ovf));
  endtask

  task automatic set_dual(input logic [VLEN-1:0] pc0, input logic [VLEN-1:0] pc1);
    ack      = 2'b11;
    pc[0]    = pc0;            pc[1]    = pc1;
    instr[0] = 32'h0000_0013;  instr[1] = 32'h0020_8113;
    we       = 2'b11;          fpr      = 2'b00;
    waddr[0] = 5'd3;           waddr[1] = 5'd4;
    wdata[0] = XLEN'(pc0);     wdata[1] = XLEN'(pc1) ^ 64'hFF;
  endtask

  task automatic drain(input int cycles);
    idle_inputs();
    ready = 1'b1;
    for (int i = 0; i < cycles; i++) run_cycle();
  endtask

  task automatic fill_overflow();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_dual(64'h2000 + 64'(16 * i), 64'h2004 + 64'(16 * i));
      run_cycle();
    end
  endtask

  initial begin
    idle_inputs();
    ready = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", 512'(valid), 512'(0));
    check("rst_rec", 512'(rec), 512'(0));
    check("rst_ovf", 512'(ovf), 512'(0));
    check("rst_drop", 512'(drop_cnt), 512'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // Single commit; head is visible one cycle after the push.
    ack = 2'b01; pc[0] = 64'h8000_0000; instr[0] = 32'h0010_0093;
    we = 2'b01; waddr[0] = 5'd1; wdata[0] = 64'd1;
    run_cycle();
    check("t1_kind", 512'(rec.kind), 512'(INSTR));
    check("t1_wdata", 512'(rec.wdata), 512'(1));
    drain(2);

    // Dual commit while draining; port 1 has we=0 so its wdata must read zero.
    ready = 1'b1;
    set_dual(64'h100, 64'h104);
    we = 2'b01; dbg = 1'b1;
    run_cycle();
    drain(3);

    // Five dual-commit cycles into a stalled sink: the fifth overflows by two.
    fill_overflow();
    check("t3_ovf", 512'(ovf), 512'(1));
    check("t3_drop", 512'(drop_cnt), 512'(2));
    drain(12);

    // Exception alongside a dual commit.
    ready = 1'b1;
    set_dual(64'h300, 64'h304);
    ex_valid = 1'b1; ex_cause = 64'd2; ex_tval = 64'hdead; priv = 2'd1;
    run_cycle();
    drain(5);

    // Clear while full and pushing.
    fill_overflow();
    set_dual(64'h400, 64'h404);
    clear = 1'b1;
    run_cycle();
    idle_inputs();
    check("t5_valid", 512'(valid), 512'(0));
    check("t5_drop", 512'(drop_cnt), 512'(0));
    check("t5_ovf", 512'(ovf), 512'(0));
    set_dual(64'h500, 64'h504);
    run_cycle();
    drain(4);

    // Random traffic with occasional clears and sink stalls.
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      ack      = 2'($urandom_range(0, 3));
      ex_valid = ($urandom_range(0, 5) == 0);
      ready    = ($urandom_range(0, 1) == 1);
      clear    = ($urandom_range(0, 99) == 0);
      priv     = 2'($urandom_range(0, 3));
      dbg      = 1'($urandom_range(0, 1));
      for (int p = 0; p < NR; p++) begin
        pc[p]    = {32'h0, $urandom};
        instr[p] = $urandom;
        we[p]    = 1'($urandom_range(0, 1));
        fpr[p]   = 1'($urandom_range(0, 1));
        waddr[p] = 5'($urandom_range(0, 31));
        wdata[p] = {$urandom, $urandom};
      end
      ex_cause = 64'($urandom_range(0, 15));
      ex_tval  = {$urandom, $urandom};
      run_cycle();
    end
    drain(16);

    // Asynchronous reset in the middle of a drain.
    fill_overflow();
    drain(3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 512'(valid), 512'(0));
    check("t6_rec", 512'(rec), 512'(0));
    check("t6_ovf", 512'(ovf), 512'(0));
    check("t6_drop", 512'(drop_cnt), 512'(0));
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_dual(64'h600, 64'h604);
    ready = 1'b0;
    run_cycle();
    run_cycle();
    drain(6);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
